// File: rtl/jk_excitation_driver.sv
// Drives J/K pulses into an external JK flip-flop bank to reach a requested target word.
// Each transaction is checked by reading Q back, with a bounded number of retries.
module jk_excitation_driver #(
    parameter int WIDTH       = 4,
    parameter int TOGGLE_PREF = 0,
    parameter int MAX_RETRY   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             fail,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
    } jk_t;

    localparam logic [2:0] MAX_RETRY_L = 3'(MAX_RETRY);

    // Only bits that differ from the target get a J or K pulse; matching bits hold.
    function automatic jk_t excitation(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
        jk_t              r;
        logic [WIDTH-1:0] diff;
        diff = q ^ t;
        if (TOGGLE_PREF != 0) begin
            r.j = diff;
            r.k = diff;
        end else begin
            r.j = diff & t;
            r.k = diff & ~t;
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [2:0]       retry_q, retry_d;
    jk_t              jk_q, jk_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [7:0]       err_q, err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        jk_d     = '0;
        done_d   = 1'b0;
        fail_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    target_d = tgt_data;
                    jk_d     = excitation(q_fb, tgt_data);
                    retry_d  = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (retry_q < MAX_RETRY_L) begin
                        retry_d = retry_q + 3'd1;
                        jk_d    = excitation(q_fb, target_q);
                        state_d = DRIVE;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            retry_q  <= '0;
            jk_q     <= '0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            jk_q     <= jk_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign j_out     = jk_q.j;
    assign k_out     = jk_q.k;
    assign done      = done_q;
    assign fail      = fail_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (set/reset and toggle encodings), each attached to a small JK bank model.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] tgt_data;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic [3:0] j0, k0, j1, k1;
    logic       done0, fail0, done1, fail1;
    logic [7:0] err0, err1;
    logic [3:0] bank0, bank1, q_fb0, q_fb1, stuck0;
    logic       ld0, ld1;
    logic [3:0] ld_val0, ld_val1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(4), .TOGGLE_PREF(0), .MAX_RETRY(2)) u_dut0 (
        .clk(clk), .reset(reset), .tgt_valid(valid0), .tgt_data(tgt_data), .tgt_ready(ready0),
        .q_fb(q_fb0), .j_out(j0), .k_out(k0), .done(done0), .fail(fail0), .err_count(err0)
    );

    jk_excitation_driver #(.WIDTH(4), .TOGGLE_PREF(1), .MAX_RETRY(2)) u_dut1 (
        .clk(clk), .reset(reset), .tgt_valid(valid1), .tgt_data(tgt_data), .tgt_ready(ready1),
        .q_fb(q_fb1), .j_out(j1), .k_out(k1), .done(done1), .fail(fail1), .err_count(err1)
    );

    // JK bank model: Q+ = J&~Q | ~K&Q, with a preload path for test setup.
    always @(posedge clk) begin
        if (ld0) bank0 <= ld_val0;
        else     bank0 <= (j0 & ~bank0) | (~k0 & bank0);
        if (ld1) bank1 <= ld_val1;
        else     bank1 <= (j1 & ~bank1) | (~k1 & bank1);
    end

    assign q_fb0 = bank0 & ~stuck0;
    assign q_fb1 = bank1;

    task automatic load_bank(input bit use1, input logic [3:0] v);
        if (use1) begin ld1 = 1'b1; ld_val1 = v; end
        else      begin ld0 = 1'b1; ld_val0 = v; end
        @(negedge clk);
        ld0 = 1'b0;
        ld1 = 1'b0;
    endtask

    // Offer one word; returns at the negedge just after the accepting edge.
    task automatic accept(input bit use1, input logic [3:0] v);
        if (use1) valid1 = 1'b1;
        else      valid0 = 1'b1;
        tgt_data = v;
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        stuck0 = 4'b0000;
        ld0 = 1'b1; ld_val0 = 4'b0000;
        ld1 = 1'b1; ld_val1 = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            valid0   = 1'($urandom_range(0, 1));
            valid1   = 1'($urandom_range(0, 1));
            tgt_data = 4'($urandom);
            @(negedge clk);
            checks++; if (ready0 !== 1'b1 || ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b want 1/1", ready0, ready1); end
            checks++; if ({j0, k0, j1, k1} !== 16'h0) begin errors++; $display("FAIL reset_jk got %h want 0000", {j0, k0, j1, k1}); end
            checks++; if ({done0, fail0, done1, fail1} !== 4'b0) begin errors++; $display("FAIL reset_done_fail got %b want 0000", {done0, fail0, done1, fail1}); end
            checks++; if (err0 !== 8'd0 || err1 !== 8'd0) begin errors++; $display("FAIL reset_err got %0d/%0d want 0/0", err0, err1); end
        end
        ld0 = 1'b0; ld1 = 1'b0;
        valid1 = 1'b0;
        reset  = 1'b0;
        accept(1'b0, 4'b0000);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_first_accept ready got %b want 0", ready0); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL reset_first_done got %b want 1", done0); end
        @(negedge clk);
    endtask

    // One matching transaction: J/K for one cycle at n=0, done at n=2, ready again from n=2.
    task automatic test_clean_path(input string name, input bit use1, input logic [3:0] bank,
                                   input logic [3:0] tgt, input logic [3:0] jexp,
                                   input logic [3:0] kexp, input logic [3:0] bank_exp);
        logic [3:0] oj, ok, ob;
        logic       od, of, ordy;
        logic [7:0] oe;
        load_bank(use1, bank);
        accept(use1, tgt);
        for (int n = 0; n < 4; n++) begin
            oj = use1 ? j1 : j0;          ok = use1 ? k1 : k0;
            ob = use1 ? bank1 : bank0;    od = use1 ? done1 : done0;
            of = use1 ? fail1 : fail0;    ordy = use1 ? ready1 : ready0;
            oe = use1 ? err1 : err0;
            checks++; if (oj !== (n == 0 ? jexp : 4'b0)) begin errors++; $display("FAIL %s j n=%0d got %b want %b", name, n, oj, (n == 0 ? jexp : 4'b0)); end
            checks++; if (ok !== (n == 0 ? kexp : 4'b0)) begin errors++; $display("FAIL %s k n=%0d got %b want %b", name, n, ok, (n == 0 ? kexp : 4'b0)); end
            checks++; if (od !== (n == 2)) begin errors++; $display("FAIL %s done n=%0d got %b want %b", name, n, od, (n == 2)); end
            checks++; if (of !== 1'b0) begin errors++; $display("FAIL %s fail n=%0d got %b want 0", name, n, of); end
            checks++; if (ordy !== (n >= 2)) begin errors++; $display("FAIL %s ready n=%0d got %b want %b", name, n, ordy, (n >= 2)); end
            if (n >= 1) begin
                checks++; if (ob !== bank_exp) begin errors++; $display("FAIL %s bank n=%0d got %b want %b", name, n, ob, bank_exp); end
            end
            if (n == 2) begin
                checks++; if (oe !== 8'd0) begin errors++; $display("FAIL %s err got %0d want 0", name, oe); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_handshake;
        load_bank(1'b0, 4'b0000);
        valid0   = 1'b1;
        tgt_data = 4'b1010;
        @(negedge clk);
        tgt_data = 4'b0101;
        checks++; if (j0 !== 4'b1010 || ready0 !== 1'b0) begin errors++; $display("FAIL hs_drive j/ready got %b/%b want 1010/0", j0, ready0); end
        @(negedge clk);
        tgt_data = 4'b1100;
        checks++; if (j0 !== 4'b0000 || ready0 !== 1'b0) begin errors++; $display("FAIL hs_check j/ready got %b/%b want 0000/0", j0, ready0); end
        @(negedge clk);
        valid0 = 1'b0;
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL hs_done got %b want 1", done0); end
        checks++; if (bank0 !== 4'b1010) begin errors++; $display("FAIL hs_bank got %b want 1010", bank0); end
        @(negedge clk);
        checks++; if (done0 !== 1'b0 || ready0 !== 1'b1 || j0 !== 4'b0) begin errors++; $display("FAIL hs_no_extra done/ready/j got %b/%b/%b want 0/1/0000", done0, ready0, j0); end
        checks++; if (bank0 !== 4'b1010) begin errors++; $display("FAIL hs_bank_after got %b want 1010", bank0); end
    endtask

    task automatic test_stuck_bit;
        logic [6:0]  jpulse;
        logic [7:0]  err_exp [7];
        jpulse  = 7'b0010101;
        err_exp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
        stuck0  = 4'b0001;
        load_bank(1'b0, 4'b0000);
        accept(1'b0, 4'b0001);
        for (int n = 0; n < 7; n++) begin
            checks++; if (j0 !== (jpulse[n] ? 4'b0001 : 4'b0000) || k0 !== 4'b0) begin errors++; $display("FAIL stuck_jk n=%0d got %b/%b want %b/0000", n, j0, k0, (jpulse[n] ? 4'b0001 : 4'b0000)); end
            checks++; if (fail0 !== (n == 6) || done0 !== 1'b0) begin errors++; $display("FAIL stuck_fail n=%0d got fail=%b done=%b want fail=%b done=0", n, fail0, done0, (n == 6)); end
            checks++; if (ready0 !== (n == 6)) begin errors++; $display("FAIL stuck_ready n=%0d got %b want %b", n, ready0, (n == 6)); end
            checks++; if (err0 !== err_exp[n]) begin errors++; $display("FAIL stuck_err n=%0d got %0d want %0d", n, err0, err_exp[n]); end
            @(negedge clk);
        end
        checks++; if (fail0 !== 1'b0 || ready0 !== 1'b1) begin errors++; $display("FAIL stuck_after fail/ready got %b/%b want 0/1", fail0, ready0); end
    endtask

    task automatic test_saturation;
        int exp;
        for (int f = 2; f <= 89; f++) begin
            accept(1'b0, 4'b0001);
            repeat (6) @(negedge clk);
            exp = (3 * f > 255) ? 255 : 3 * f;
            checks++; if (fail0 !== 1'b1) begin errors++; $display("FAIL sat_fail f=%0d got %b want 1", f, fail0); end
            checks++; if (err0 !== 8'(exp)) begin errors++; $display("FAIL sat_err f=%0d got %0d want %0d", f, err0, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        stuck0 = 4'b0000;
        load_bank(1'b0, 4'b0000);
        accept(1'b0, 4'b1111);
        checks++; if (j0 !== 4'b1111) begin errors++; $display("FAIL rmid_drive j got %b want 1111", j0); end
        reset = 1'b1;
        #1;
        checks++; if (j0 !== 4'b0 || k0 !== 4'b0) begin errors++; $display("FAIL rmid_jk_async got %b/%b want 0000/0000", j0, k0); end
        checks++; if (ready0 !== 1'b1 || err0 !== 8'd0) begin errors++; $display("FAIL rmid_state ready/err got %b/%0d want 1/0", ready0, err0); end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks++; if (done0 !== 1'b0 || fail0 !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse n=%0d got done=%b fail=%b want 0/0", n, done0, fail0); end
            checks++; if (bank0 !== 4'b0000) begin errors++; $display("FAIL rmid_bank n=%0d got %b want 0000", n, bank0); end
            @(negedge clk);
        end
    endtask

    initial begin
        valid0 = 1'b0; valid1 = 1'b0; tgt_data = 4'b0;
        test_reset;
        test_clean_path("set_path",    1'b0, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1010);
        test_clean_path("hold_path",   1'b0, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0110);
        test_clean_path("mixed_path",  1'b0, 4'b1010, 4'b0011, 4'b0001, 4'b1000, 4'b0011);
        test_clean_path("toggle_path", 1'b1, 4'b0011, 4'b0101, 4'b0110, 4'b0110, 4'b0101);
        test_handshake;
        test_stuck_bit;
        test_saturation;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives the J/K inputs of an external bank of JK flip-flops so that the bank's outputs move to a requested target word, then reads the bank's Q outputs back to confirm the update. It is the control-side counterpart of the JK flip-flop. A requester hands it target words over a valid/ready handshake. It computes per-bit excitation from the current Q feedback, pulses J/K for exactly one cycle, and verifies the result with a bounded retry.

## Interface
Parameters:
- WIDTH, 4, number of flip-flops in the driven bank
- TOGGLE_PREF, 0, excitation encoding for changing bits: 0 uses set/reset, 1 uses toggle
- MAX_RETRY, 2, extra drive attempts after a failed readback, range 0-7

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- tgt_valid  input  1  target word offered
- tgt_data  input  WIDTH  requested Q value
- tgt_ready  output  1  block can accept a target
- q_fb  input  WIDTH  current Q outputs of the external JK bank
- j_out  output  WIDTH  J inputs to the bank (registered)
- k_out  output  WIDTH  K inputs to the bank (registered)
- done  output  1  one-cycle pulse: readback matched target
- fail  output  1  one-cycle pulse: retries exhausted without a match
- err_count  output  8  count of mismatching readbacks; saturates at 255

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - tgt_ready=1; j_out=k_out=0.
  - On tgt_valid&&tgt_ready at a clock edge: latch tgt_data into target; load j_out/k_out from excitation(q_fb, tgt_data); clear retry counter; go to DRIVE.
- Excitation per bit i, from q=q_fb[i] and t=target[i]:
  - q=t: J=0, K=0 (hold).
  - q=0, t=1: J=1, K=0 when TOGGLE_PREF=0; J=1, K=1 when TOGGLE_PREF=1.
  - q=1, t=0: J=0, K=1 when TOGGLE_PREF=0; J=1, K=1 when TOGGLE_PREF=1.
- DRIVE: lasts exactly one cycle. At the next edge, j_out/k_out return to 0 and the state goes to CHECK.
- CHECK: at the next edge compare q_fb with target.
  - Match: done=1 next cycle; go to IDLE.
  - Mismatch with retry < MAX_RETRY: err_count+1 (saturating); retry+1; reload j_out/k_out from excitation(q_fb, target); go to DRIVE.
  - Mismatch with retry = MAX_RETRY: err_count+1 (saturating); fail=1 next cycle; go to IDLE.
- tgt_valid outside IDLE is ignored; tgt_ready=0 in DRIVE and CHECK. tgt_ready is decoded from state only.
- done and fail are never high together and are never high for two consecutive cycles.
- err_count persists across transactions; only reset clears it.

## Timing
- Reset values, applied asynchronously while reset=1: state IDLE, tgt_ready=1, j_out=0, k_out=0, done=0, fail=0, err_count=0, target=0, retry=0.
- Reset asserted mid-transaction: the transaction is discarded, J/K go to 0 immediately, and no done/fail is issued.
- Latency, with accept at edge E0:
  - j_out/k_out valid in cycle E0-E1.
  - The bank samples them at E1.
  - CHECK compares q_fb at E2.
  - done/fail is high in cycle E2-E3.
- Earliest next accept is E3, so throughput is 1 word per 3 cycles with no retries.
- Each retry adds 2 cycles. Worst case, done/fail is asserted (2+2·MAX_RETRY) edges after accept.
- q_fb must reflect the bank state one cycle after the bank's sampling edge; the block registers no q_fb synchronizer.

## Test plan
- Reset: hold reset across 2 edges with random inputs -> tgt_ready=1, j_out=k_out=0, done=fail=0, err_count=0. Release reset -> accept on the first edge with tgt_valid=1.
- Set path, bench JK model attached, TOGGLE_PREF=0, bank=0000, target 1010:
  - j_out=1010, k_out=0000 for exactly one cycle.
  - bank=1010; done pulses at E2-E3; err_count=0.
- Hold path: bank=0110, target 0110 -> j_out=k_out=0000 throughout; done at E2-E3.
- Toggle path, TOGGLE_PREF=1: bank=0011, target 0101 -> j_out=k_out=0110 for one cycle; bank=0101; done.
- Stuck bit, MAX_RETRY=2: q_fb[0] forced 0, bank=0000, target 0001 ->
  - three one-cycle J pulses with j_out=0001;
  - err_count=3; fail pulses 6 edges after accept; tgt_ready=1 afterwards;
  - back-to-back failures saturate err_count at 255.
- Handshake/reset: hold tgt_valid=1 with a changing tgt_data during DRIVE/CHECK -> the latched target is unchanged and no extra accept occurs. Assert reset during DRIVE -> j_out/k_out=0 before the next edge and no done/fail.
